// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: shared format codes, opcodes, FSM states and immediate range limits for the RV32I encoder.
package instr_enc_pkg;
  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_LI  = 3'd6,
    FMT_RSV = 3'd7
  } fmt_e;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_LI2   = 2'd2
  } state_e;
  localparam logic [6:0] OP_LUI = 7'h37;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;
endpackage

// File: rtl/imm_field_pack.sv
// imm_field_pack: scatters an immediate into its RV32I bit positions; range flag only with INSTR_ENCODER_RANGE_CHECK_EN.
module imm_field_pack
  import instr_enc_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [31:0] imm,
  output logic [31:0] bits,
  output logic        err
);
  assign bits = fmt == FMT_I ? {imm[11:0], 20'b0} :
                fmt == FMT_S ? {imm[11:5], 13'b0, imm[4:0], 7'b0} :
                fmt == FMT_B ? {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0} :
                fmt == FMT_U ? {imm[31:12], 12'b0} :
                fmt == FMT_J ? {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0} :
                32'b0;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic signed [31:0] s;
  assign s = $signed(imm);
  assign err = (fmt == FMT_I || fmt == FMT_S) ? (s < IMM12_MIN || s > IMM12_MAX) :
               fmt == FMT_B ? (s < IMM13_MIN || s > IMM13_MAX || imm[0]) :
               fmt == FMT_J ? (s < IMM21_MIN || s > IMM21_MAX || imm[0]) :
               fmt == FMT_U ? |imm[11:0] :
               1'b0;
`else
  assign err = 1'b0;
`endif
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: one-cycle RV32I instruction encoder with LI pseudo split into LUI+ADDI.
// Immediate range errors are reported only when INSTR_ENCODER_RANGE_CHECK_EN is defined.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err
);
  state_e      state, state_nx;
  fmt_e        fmt;
  logic        started, accept, li_two, pack_err, new_err;
  logic        use_rd, use_rs1, use_rs2, use_f3;
  logic [31:0] imm_bits, word, new_word, addi_rd, pend;
  logic [19:0] hi;
  logic [11:0] lo;
  assign fmt = fmt_e'(in_fmt);
  imm_field_pack u_pack (
    .fmt  (fmt),
    .imm  (in_imm),
    .bits (imm_bits),
    .err  (pack_err)
  );
  assign use_rd  = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
  assign use_rs1 = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
  assign use_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};
  assign use_f3  = use_rs1;
  assign word = imm_bits | {fmt == FMT_R ? in_funct7 : 7'b0, use_rs2 ? in_rs2 : 5'b0,
                            use_rs1 ? in_rs1 : 5'b0, use_f3 ? in_funct3 : 3'b0,
                            use_rd ? in_rd : 5'b0, in_opcode};
  // Rounding the upper part compensates for ADDI sign-extending the low 12 bits.
  assign hi = in_imm[31:12] + {19'b0, in_imm[11]};
  assign lo = in_imm[11:0];
  assign li_two = fmt == FMT_LI && hi != 20'b0 && lo != 12'b0;
  assign addi_rd = {lo, in_rd, 3'b0, in_rd, OP_IMM};
  assign new_word = fmt == FMT_RSV ? RESET_INSTR :
                    fmt == FMT_LI  ? (hi == 20'b0 ? {lo, 5'b0, 3'b0, in_rd, OP_IMM} : {hi, in_rd, OP_LUI}) :
                    word;
  assign new_err = fmt == FMT_RSV || (fmt != FMT_LI && pack_err);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= ST_EMPTY;
      started <= 1'b0;
    end else begin
      state   <= state_nx;
      started <= 1'b1;
    end
  always_comb
    state_nx = accept ? (li_two ? ST_LI2 : ST_FULL) :
               state == ST_LI2 ? (out_ready ? ST_FULL : ST_LI2) :
               (state == ST_FULL && out_ready) ? ST_EMPTY : state;
  always_comb begin
    in_ready  = started && (state == ST_EMPTY || (state == ST_FULL && out_ready));
    out_valid = state != ST_EMPTY;
    accept    = in_valid && in_ready;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_instr <= RESET_INSTR;
      out_err   <= 1'b0;
      pend      <= 32'b0;
    end else if (accept) begin
      out_instr <= new_word;
      out_err   <= new_err;
      pend      <= addi_rd;
    end else if (state == ST_LI2 && out_ready) begin
      out_instr <= pend;
      out_err   <= 1'b0;
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder with immediate assertions.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = 3'd0;
  logic [6:0]  in_opcode = 7'd0;
  logic [6:0]  in_funct7 = 7'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [4:0]  in_rs1 = 5'd0;
  logic [4:0]  in_rs2 = 5'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [31:0] in_imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_err;
  int checks = 0;
  int errors = 0;
  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int n;
    in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask
  initial begin
    #22;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_err", {31'b0, out_err}, 32'd0);
    check("rst_out_instr", out_instr, 32'h00000013);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_first_edge", {31'b0, in_ready}, 32'd0);
    step();
    check("in_ready_after_first_edge", {31'b0, in_ready}, 32'd1);
    send(3'd1, 7'h13, 3'd0, 7'h7F, 5'd1, 5'd2, 5'd31, 32'hFFFFFFFF);
    check("i_addi_neg1", out_instr, 32'hFFF10093);
    check("i_addi_err", {31'b0, out_err}, 32'd0);
    check("i_addi_valid", {31'b0, out_valid}, 32'd1);
    send(3'd3, 7'h63, 3'd0, 7'h7F, 5'd9, 5'd1, 5'd2, 32'd8);
    check("b_beq_8", out_instr, 32'h00208463);
    send(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF);
    check("r_sub", out_instr, 32'h402081B3);
    check("r_err", {31'b0, out_err}, 32'd0);
    send(3'd2, 7'h23, 3'd2, 7'h7F, 5'd7, 5'd1, 5'd2, 32'hFFFFFFFC);
    check("s_sw_neg4", out_instr, 32'hFE20AE23);
    send(3'd4, 7'h37, 3'd7, 7'h7F, 5'd5, 5'd9, 5'd9, 32'h12345000);
    check("u_lui", out_instr, 32'h123452B7);
    send(3'd5, 7'h6F, 3'd7, 7'h7F, 5'd1, 5'd9, 5'd9, 32'd2048);
    check("j_jal_2048", out_instr, 32'h001000EF);
    send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFE);
    check("j_jal_neg2", out_instr, 32'hFFFFF06F);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd2048);
    check("i_imm_2048_word", out_instr, 32'h80010093);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    check("i_imm_2048_err", {31'b0, out_err}, 32'd1);
`else
    check("i_imm_2048_err", {31'b0, out_err}, 32'd0);
`endif
    send(3'd7, 7'h33, 3'd1, 7'h11, 5'd3, 5'd4, 5'd5, 32'h0);
    check("rsv_word", out_instr, 32'h00000013);
    check("rsv_err", {31'b0, out_err}, 32'd1);
    send(3'd6, 7'h00, 3'd0, 7'h00, 5'd6, 5'd0, 5'd0, 32'd5);
    check("li_small", out_instr, 32'h00500313);
    check("li_small_err", {31'b0, out_err}, 32'd0);
    step();
    check("li_small_single", {31'b0, out_valid}, 32'd0);
    send(3'd6, 7'h00, 3'd0, 7'h00, 5'd6, 5'd0, 5'd0, 32'hFFFFFFFF);
    check("li_neg1", out_instr, 32'hFFF00313);
    send(3'd6, 7'h00, 3'd0, 7'h00, 5'd7, 5'd0, 5'd0, 32'h12345000);
    check("li_lui_only", out_instr, 32'h123453B7);
    step();
    check("li_lui_only_single", {31'b0, out_valid}, 32'd0);
    send(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    check("li_beat1", out_instr, 32'h123462B7);
    check("li_beat1_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    check("li_beat2", out_instr, 32'hFFF28293);
    check("li_beat2_valid", {31'b0, out_valid}, 32'd1);
    check("li_beat2_err", {31'b0, out_err}, 32'd0);
    step();
    check("li_done", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_stall_word", out_instr, 32'hFFF10093);
      check("full_stall_valid", {31'b0, out_valid}, 32'd1);
      check("full_stall_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("full_stall_release", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    send(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    for (int i = 0; i < 3; i++) begin
      step();
      check("li2_stall_word", out_instr, 32'h123462B7);
      check("li2_stall_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("li2_stall_beat2", out_instr, 32'hFFF28293);
    step();
    check("li2_stall_done", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    send(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("li2_rst_valid", {31'b0, out_valid}, 32'd0);
    check("li2_rst_word", out_instr, 32'h00000013);
    check("li2_rst_in_ready", {31'b0, in_ready}, 32'd0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("li2_rst_no_addi", {31'b0, out_valid}, 32'd0);
      check("li2_rst_word_kept", out_instr, 32'h00000013);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
